// File: rtl/dmem_pkg.sv
// Shared types for the data-memory master: access sizes, FSM states, address helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_GAP  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_e;

    // Size code 11 behaves as a word access.
    function automatic logic is_word(input logic [1:0] sz);
        return sz[1];
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        if (sz[1])
            return lo != 2'b00;
        if (sz == SZ_HALF)
            return lo[0];
        return 1'b0;
    endfunction

    function automatic logic [1:0] align_lo(input logic [1:0] sz, input logic [1:0] lo);
        if (sz[1])
            return 2'b00;
        if (sz == SZ_HALF)
            return {lo[1], 1'b0};
        return lo;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU request/response and word-RAM signals of the data-memory master.
interface dmem_if;

    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        cpu_stall;

    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_ack;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_dout, mem_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, cpu_stall,
        output mem_cs, mem_we, mem_addr, mem_din
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_dout, mem_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, cpu_stall,
        input  mem_cs, mem_we, mem_addr, mem_din
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane extraction with sign/zero extension for loads and
// read-modify-write merge of sub-word store data into a RAM word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  b;
    logic [15:0] h;

    assign bsh = {lo, 3'b000};
    assign hsh = {lo[1], 4'b0000};

    always_comb begin
        load_data = '0;
        merged    = rdata;
        b         = 8'(rdata >> bsh);
        h         = 16'(rdata >> hsh);
        unique case (1'b1)
            size[1]: begin
                load_data = rdata;
                merged    = wdata;
            end
            size == SZ_HALF: begin
                load_data = {{16{~is_unsigned & h[15]}}, h};
                merged    = (rdata & ~(32'h0000_FFFF << hsh))
                          | ({16'h0, wdata[15:0]} << hsh);
            end
            size == SZ_BYTE: begin
                load_data = {{24{~is_unsigned & b[7]}}, b};
                merged    = (rdata & ~(32'h0000_00FF << bsh))
                          | ({24'h0, wdata[7:0]} << bsh);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_master.sv
// CPU load/store master for a word-only RAM with timeout and sub-word RMW.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned requests instead of aligning them.
module dmem_master
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input logic  clk,
    input logic  rst,
    dmem_if.master bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state;
    state_e        state_n;
    logic [CW-1:0] cnt;
    logic [1:0]    size_q;
    logic [1:0]    lo_q;
    logic          we_q;
    logic          uns_q;
    logic [31:0]   wdata_q;
    logic          tmo;
    logic          mis;
    logic [1:0]    lo_in;
    logic [31:0]   load_data;
    logic [31:0]   merged;

    assign lo_in = align_lo(bus.req_size, bus.req_addr[1:0]);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign bus.req_ready = (state == S_IDLE);
    assign bus.cpu_stall = bus.req_valid & ~bus.rsp_valid;

    dmem_lane_align u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .lo          (lo_q),
        .rdata       (bus.mem_dout),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_comb begin
        state_n = state;
        tmo     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (mis)
                        state_n = S_RESP;
                    else if (bus.req_we && is_word(bus.req_size))
                        state_n = S_WR;
                    else
                        state_n = S_RD;
                end
            end
            S_RD, S_WR: begin
                if (bus.mem_ack) begin
                    state_n = (state == S_RD && we_q) ? S_GAP : S_RESP;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    tmo     = 1'b1;
                    state_n = S_RESP;
                end
            end
            S_GAP:   state_n = S_WR;
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            size_q        <= '0;
            lo_q          <= '0;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            wdata_q       <= '0;
            bus.mem_cs    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_din   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            state         <= state_n;
            bus.mem_cs    <= (state_n == S_RD) || (state_n == S_WR);
            bus.mem_we    <= (state_n == S_WR);
            bus.rsp_valid <= (state_n == S_RESP);
            // Counter restarts on every RD/WR entry, so a sub-word store gets two budgets.
            cnt <= (state_n == state && (state == S_RD || state == S_WR))
                 ? cnt + 1'b1 : '0;

            if (state == S_IDLE && bus.req_valid) begin
                size_q        <= bus.req_size;
                lo_q          <= lo_in;
                we_q          <= bus.req_we;
                uns_q         <= bus.req_unsigned;
                wdata_q       <= bus.req_wdata;
                bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                bus.mem_din   <= bus.req_wdata;
                bus.rsp_rdata <= '0;
                bus.rsp_err   <= mis;
            end

            if (state == S_RD && bus.mem_ack) begin
                if (we_q)
                    bus.mem_din <= merged;
                else
                    bus.rsp_rdata <= load_data;
            end

            if (tmo) begin
                bus.rsp_err   <= 1'b1;
                bus.rsp_rdata <= '0;
            end

            if (state == S_RESP) begin
                bus.rsp_err   <= 1'b0;
                bus.rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_master.sv
// Directed bench for dmem_master: RAM responder, byte-level reference model,
// per-cycle response compare plus literal spot checks.
module tb_dmem_master;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dmem_if bus ();

    dmem_master #(.TIMEOUT_CYCLES(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    int total = 0;
    int bad   = 0;

    rsp_t expq[$];

    logic [31:0] ram [logic [31:0]];
    logic [31:0] mdl [logic [31:0]];
    bit          ack_en = 1'b1;
    int          lat    = 0;
    int          cs_wait = 0;

    int          cs_rises = 0;
    int          cs_high  = 0;
    int          low_run  = 0;
    int          last_gap = 0;
    logic        prev_cs  = 1'b0;
    logic [31:0] wr_din   = '0;
    logic [31:0] last_addr = '0;

    logic [31:0] last_rdata;
    logic        last_err;
    int          d_rises;
    int          d_high;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h80) return 32'h8899_AABB;
        if (a == 32'h40) return 32'h1122_3344;
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_word(a);
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : init_word(a);
    endfunction

    // Reference behaviour worked out byte by byte from the access rules.
    function automatic rsp_t model_req(input bit we, input logic [1:0] size,
                                       input bit uns, input logic [31:0] addr,
                                       input logic [31:0] wdata, input bit tmo);
        rsp_t        r;
        int          nb;
        int          off;
        logic [31:0] m;
        logic [31:0] a;
        logic [31:0] wa;
        logic [31:0] w;
        logic [31:0] v;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        m  = 32'(nb - 1);
        r.rdata = '0;
        r.err   = 1'b0;
        if (TRAP && (addr & m) != 0) begin
            r.err = 1'b1;
            return r;
        end
        if (tmo) begin
            r.err = 1'b1;
            return r;
        end
        a   = addr & ~m;
        wa  = {a[31:2], 2'b00};
        off = int'(a[1:0]);
        w   = mdl_rd(wa);
        if (we) begin
            for (int i = 0; i < nb; i++)
                w[8*(off+i) +: 8] = wdata[8*i +: 8];
            mdl[wa] = w;
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++)
                v[8*i +: 8] = w[8*(off+i) +: 8];
            if (!uns && nb < 4 && v[8*nb-1])
                v = v | (32'hFFFF_FFFF << (8*nb));
            r.rdata = v;
        end
        return r;
    endfunction

    // Word RAM: acknowledges after lat extra cycles of mem_cs.
    always @(negedge clk) begin
        if (bus.mem_ack || !bus.mem_cs) begin
            bus.mem_ack = 1'b0;
            cs_wait = 0;
        end else if (ack_en && cs_wait >= lat) begin
            bus.mem_ack = 1'b1;
            if (bus.mem_we)
                ram[bus.mem_addr] = bus.mem_din;
            else
                bus.mem_dout = ram_rd(bus.mem_addr);
            cs_wait = 0;
        end else begin
            cs_wait++;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_cs) begin
            cs_high++;
            last_addr = bus.mem_addr;
            if (!prev_cs) begin
                cs_rises++;
                last_gap = low_run;
            end
            if (bus.mem_we)
                wr_din = bus.mem_din;
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_cs = bus.mem_cs;
    end

    // Compare process: stall rule every cycle, each response against the model.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst) begin
            chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.req_valid & ~bus.rsp_valid));
            if (bus.rsp_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit tmo);
        int r0;
        int h0;
        int n;
        bit got;
        expq.push_back(model_req(we, size, uns, addr, wdata, tmo));
        @(negedge clk);
        #1;
        r0 = cs_rises;
        h0 = cs_high;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        n   = 0;
        got = 1'b0;
        while (n < 200 && !got) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid) begin
                got        = 1'b1;
                last_rdata = bus.rsp_rdata;
                last_err   = bus.rsp_err;
            end
        end
        #1;
        bus.req_valid = 1'b0;
        d_rises = cs_rises - r0;
        d_high  = cs_high - h0;
        if (!got) begin
            chk("rsp_wait_expired", 32'd0, 32'd1);
            void'(expq.pop_back());
            last_rdata = 'x;
            last_err   = 1'bx;
        end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mem_cs", 32'(bus.mem_cs), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        #1 rst = 1'b0;

        do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b0);
        chk("lw80_data", last_rdata, 32'h8899_AABB);
        chk("lw80_err", 32'(last_err), 32'd0);
        chk("lw80_cs_rises", 32'(d_rises), 32'd1);

        do_req(1'b0, 2'b00, 1'b0, 32'h82, 32'h0, 1'b0);
        chk("lb82", last_rdata, 32'hFFFF_FF99);
        do_req(1'b0, 2'b00, 1'b1, 32'h82, 32'h0, 1'b0);
        chk("lbu82", last_rdata, 32'h0000_0099);
        do_req(1'b0, 2'b01, 1'b0, 32'h80, 32'h0, 1'b0);
        chk("lh80", last_rdata, 32'hFFFF_AABB);

        lat = 1;
        do_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_00AB, 1'b0);
        chk("sb41_rises", 32'(d_rises), 32'd2);
        chk("sb41_gap", 32'(last_gap), 32'd1);
        chk("sb41_din", wr_din, 32'h1122_AB44);
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
        chk("lw40", last_rdata, 32'h1122_AB44);

        do_req(1'b1, 2'b01, 1'b0, 32'h42, 32'h1234_BEEF, 1'b0);
        do_req(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 1'b0);
        chk("lhu42", last_rdata, 32'h0000_BEEF);
        do_req(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 1'b0);
        chk("lh42", last_rdata, 32'hFFFF_BEEF);

        lat = 0;
        do_req(1'b1, 2'b11, 1'b0, 32'h44, 32'hCAFE_F00D, 1'b0);
        chk("sw44_rises", 32'(d_rises), 32'd1);
        do_req(1'b0, 2'b00, 1'b0, 32'h47, 32'h0, 1'b0);
        chk("lb47", last_rdata, 32'hFFFF_FFCA);
        do_req(1'b0, 2'b00, 1'b1, 32'h44, 32'h0, 1'b0);
        chk("lbu44", last_rdata, 32'h0000_000D);

        ack_en = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b1);
        chk("tmo_err", 32'(last_err), 32'd1);
        chk("tmo_data", last_rdata, 32'd0);
        chk("tmo_cs_cycles", 32'(d_high), 32'd15);
        chk("tmo_cs_after", 32'(bus.mem_cs), 32'd0);
        ack_en = 1'b1;

        do_req(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 1'b0);
        if (TRAP) begin
            chk("mis_err", 32'(last_err), 32'd1);
            chk("mis_no_cs", 32'(d_rises), 32'd0);
        end else begin
            chk("mis_err", 32'(last_err), 32'd0);
            chk("mis_data", last_rdata, 32'hBEEF_AB44);
            chk("mis_addr", last_addr, 32'h40);
        end

        ack_en = 1'b0;
        @(negedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h90;
        bus.req_wdata = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        chk("in_wr", {30'd0, bus.mem_cs, bus.mem_we}, 32'd3);
        #1;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("wrrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("wrrst_mem_cs", 32'(bus.mem_cs), 32'd0);
        chk("wrrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        #1 rst = 1'b0;
        ack_en = 1'b1;
        repeat (4) @(negedge clk);

        do_req(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b0);
        chk("lw44_after_rst", last_rdata, 32'hCAFE_F00D);
        do_req(1'b0, 2'b10, 1'b0, 32'h90, 32'h0, 1'b0);
        chk("lw90_unwritten", last_rdata, 32'hA5A5_0090);

        repeat (3) @(negedge clk);
        chk("expq_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_master.md
DMEM_MASTER -- requirements
Module: dmem_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum cycles mem_cs is held without mem_ack before a bus error.
REQ-002 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  CPU load/store request.
REQ-005 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port req_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-007 SHALL have port req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_ready  output  1  high only in IDLE.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  qualifies rsp_valid; timeout or misalignment.
REQ-014 SHALL have port cpu_stall  output  1  req_valid & ~rsp_valid.
REQ-015 SHALL have ports mem_cs, mem_we (output 1), mem_addr, mem_din (output 32): word-only RAM request, all registered.
REQ-016 SHALL have ports mem_dout (input 32) and mem_ack (input 1): RAM read data and one-cycle completion.

Function
REQ-017 SHALL implement FSM IDLE, RD, GAP, WR, RESP.
REQ-018 SHALL capture the request on an edge where req_valid and req_ready are both high: word loads and all loads go to RD, word stores go to WR, byte/half stores go to RD.
REQ-019 SHALL drive mem_cs=1 in RD/WR, mem_we=1 only in WR, and mem_addr={addr[31:2],2'b00}.
REQ-020 SHALL, on mem_ack in RD for a load, latch the lane-extracted, extended data and go to RESP.
REQ-021 SHALL, on mem_ack in RD for a sub-word store, merge the store bytes into mem_dout, register the result into mem_din, and go to GAP.
REQ-022 SHALL hold mem_cs=0 for exactly one cycle in GAP, then go to WR, so the RAM returns to idle before the direction change.
REQ-023 SHALL, on mem_ack in WR, go to RESP; word stores drive mem_din=req_wdata.
REQ-024 SHALL pulse rsp_valid for exactly one cycle in RESP and return to IDLE, giving mem_cs=0 for at least one cycle between transactions.
REQ-025 SHALL extract lanes as follows: byte uses addr[1:0]*8; half uses addr[1]*16; extension per req_unsigned.
REQ-026 SHALL count cycles in RD/WR; at TIMEOUT_CYCLES without mem_ack, drop mem_cs, go to RESP with rsp_err=1 and rsp_rdata=0; the count clears on each RD/WR entry.
REQ-027 SHALL ignore mem_ack in IDLE, GAP and RESP.

Reset
REQ-028 SHALL, on rst at any state including mid-transaction, enter IDLE on that edge with mem_cs, mem_we, rsp_valid and rsp_err at 0, mem_addr, mem_din and rsp_rdata at 0, and the timeout counter at 0; no response is issued for an aborted request.

Configuration
REQ-029 SHALL, with DMEM_MISALIGN_TRAP_EN defined, send a misaligned request (half with addr[0]=1, word with addr[1:0]!=0) directly to RESP with rsp_err=1 and no mem_cs assertion.
REQ-030 SHALL, without DMEM_MISALIGN_TRAP_EN, clear the offending low address bits to natural alignment and perform the access normally; rsp_err comes from timeout only.

Structure
REQ-031 SHALL place the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state encodings in shared package dmem_pkg.
REQ-032 SHALL put lane extract/extend and store merge in combinational sub-module dmem_lane_align; the FSM and registers stay in dmem_master.

Verification
REQ-033 SHALL cover a word load: RAM word 0x80 holds 0x8899AABB; lw 0x80 -> mem_cs rises and falls once, rsp_valid=1 for one cycle, rsp_rdata=0x8899AABB, rsp_err=0.
REQ-034 SHALL cover sign extension: the same word; lb 0x82 -> 0xFFFFFF99; lbu 0x82 -> 0x00000099; lh 0x80 -> 0xFFFFAABB.
REQ-035 SHALL cover a sub-word store: word 0x40 holds 0x11223344; sb 0x41, wdata 0xAB -> RD ack, one-cycle GAP with mem_cs=0, WR mem_din=0x1122AB44; later lw 0x40 returns 0x1122AB44.
REQ-036 SHALL cover timeout: mem_ack held 0 -> after 15 cycles mem_cs=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-037 SHALL cover misalignment: lw 0x42 -> with the macro, err=1 and mem_cs is never asserted; without it, the access goes to 0x40 and err=0.
REQ-038 SHALL cover reset during WR: rst pulsed -> next cycle IDLE, mem_cs=0, no rsp_valid, req_ready=1.
